reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader_if.sv | 28 ++
 rtl/reg_dump_reader.sv | 78 +++++++
 tb/tb_reg_dump_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_if.sv
// rtl/reg_dump_reader_if.sv - control, register-file and dump-stream signals of reg_dump_reader
interface reg_dump_reader_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [4:0]      first_i;
    logic [4:0]      last_i;
    logic            abort_i;
    logic [4:0]      rf_addr_o;
    logic [XLEN-1:0] rf_data_i;
    logic            dump_valid_o;
    logic            dump_ready_i;
    logic [4:0]      dump_addr_o;
    logic [XLEN-1:0] dump_data_o;
    logic            dump_last_o;
    logic            busy_o;
    logic            done_o;

    modport slave (
        input  start_i, first_i, last_i, abort_i, rf_data_i, dump_ready_i,
        output rf_addr_o, dump_valid_o, dump_addr_o, dump_data_o, dump_last_o, busy_o, done_o
    );

    modport master (
        output start_i, first_i, last_i, abort_i, rf_data_i, dump_ready_i,
        input  rf_addr_o, dump_valid_o, dump_addr_o, dump_data_o, dump_last_o, busy_o, done_o
    );
endinterface

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - streams a wrapping range of register-file entries as (index, value) words
module reg_dump_reader #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_dump_reader_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [4:0]      r_idx;
    logic [4:0]      r_end;
    logic [4:0]      r_dump_addr;
    logic [XLEN-1:0] r_dump_data;
    logic            r_dump_last;
    logic            w_handshake;

    assign w_handshake = (r_state == ST_SEND) && bus.dump_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 5'd0;
            r_end       <= 5'd0;
            r_dump_addr <= 5'd0;
            r_dump_data <= '0;
            r_dump_last <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_idx   <= bus.first_i;
                        r_end   <= bus.last_i;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (bus.abort_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dump_addr <= r_idx;
                        r_dump_data <= bus.rf_data_i;
                        r_dump_last <= (r_idx == r_end);
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // abort outranks a handshake landing on the same edge
                    if (bus.abort_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_handshake) begin
                        if (r_idx == r_end) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= ST_READ;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rf_addr_o    = r_idx;
    assign bus.dump_valid_o = (r_state == ST_SEND);
    assign bus.dump_addr_o  = r_dump_addr;
    assign bus.dump_data_o  = r_dump_data;
    assign bus.dump_last_o  = r_dump_last;
    assign bus.busy_o       = (r_state != ST_IDLE);
    assign bus.done_o       = (r_state == ST_DONE);
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader
module tb_reg_dump_reader;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [XLEN-1:0] rf [32];
    int n_cmp = 0;
    int n_err = 0;

    reg_dump_reader_if #(.XLEN(XLEN)) bus ();

    reg_dump_reader #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rf_data_i = rf[bus.rf_addr_o];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, bus.dump_valid_o, 0);
        chk({tag, "_busy"},  bus.busy_o, 0);
        chk({tag, "_done"},  bus.done_o, 0);
        chk({tag, "_addr"},  bus.dump_addr_o, 0);
        chk({tag, "_data"},  bus.dump_data_o, 0);
        chk({tag, "_last"},  bus.dump_last_o, 0);
        chk({tag, "_rfaddr"}, bus.rf_addr_o, 0);
    endtask

    // Called at a negedge with the DUT idle; leaves it idle at a negedge.
    // mode 0: ready always high, mode 1: random ready. stall_word/abort_word < 0 disables.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input int stall_word, input int abort_word, input bit abort_with_start);
        int n, k, cyc, stalls;
        bit aborted;
        logic [4:0] a;
        n = ((int'(l) - int'(f) + 32) % 32) + 1;
        bus.start_i = 1'b1;
        bus.first_i = f;
        bus.last_i = l;
        bus.abort_i = abort_with_start;
        bus.dump_ready_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("busy_after_start", bus.busy_o, 1);
        k = 0; cyc = 0; stalls = 0; aborted = 0;
        while (k < n && cyc < 400 && !aborted) begin
            a = f + 5'(k);
            chk("rf_addr", bus.rf_addr_o, a);
            chk("done_early", bus.done_o, 0);
            chk("busy_mid", bus.busy_o, 1);
            bus.dump_ready_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start_i = ($urandom_range(0, 3) == 0);
            bus.first_i = 5'($urandom);
            bus.last_i = 5'($urandom);
            if (bus.dump_valid_o) begin
                chk("dump_addr", bus.dump_addr_o, a);
                chk("dump_data", bus.dump_data_o, rf[a]);
                chk("dump_last", bus.dump_last_o, (k == n - 1));
                if (k == stall_word && stalls < 5) begin
                    bus.dump_ready_i = 1'b0;
                    stalls++;
                end
                if (k == abort_word) begin
                    bus.abort_i = 1'b1;
                    bus.dump_ready_i = 1'b1;
                    aborted = 1;
                end else if (bus.dump_ready_i) begin
                    k++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.dump_ready_i = 1'b1;
        if (aborted) begin
            chk("abort_valid", bus.dump_valid_o, 0);
            chk("abort_busy", bus.busy_o, 0);
            chk("abort_done", bus.done_o, 0);
            @(negedge clk);
            chk("abort_done_later", bus.done_o, 0);
        end else if (k < n) begin
            chk("timeout_words", k, n);
        end else begin
            if (mode == 0 && stall_word < 0)
                chk("throughput_cycles", cyc, 2 * n);
            chk("done_pulse", bus.done_o, 1);
            chk("done_valid", bus.dump_valid_o, 0);
            chk("done_busy", bus.busy_o, 1);
            @(negedge clk);
            chk("done_cleared", bus.done_o, 0);
            chk("idle_busy", bus.busy_o, 0);
        end
    endtask

    initial begin
        int n, aw;
        logic [4:0] f, l;
        bus.start_i = 1'b0;
        bus.first_i = '0;
        bus.last_i = '0;
        bus.abort_i = 1'b0;
        bus.dump_ready_i = 1'b0;
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", bus.busy_o, 0);

        run_dump(5'd1, 5'd3, 0, -1, -1, 1'b0);
        run_dump(5'd30, 5'd1, 0, -1, -1, 1'b0);
        run_dump(5'd4, 5'd9, 0, 1, -1, 1'b0);
        run_dump(5'd7, 5'd7, 0, -1, -1, 1'b0);
        run_dump(5'd10, 5'd15, 0, -1, 1, 1'b0);
        run_dump(5'd10, 5'd15, 1, -1, -1, 1'b1);

        // reset while a word is being offered
        bus.start_i = 1'b1; bus.first_i = 5'd5; bus.last_i = 5'd9; bus.dump_ready_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", bus.dump_valid_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        bus.dump_ready_i = 1'b1;
        @(negedge clk);
        chk("post_reset_done", bus.done_o, 0);
        chk("post_reset_busy", bus.busy_o, 0);

        for (int t = 0; t < 20; t++) begin
            f = 5'($urandom);
            l = 5'($urandom);
            n = ((int'(l) - int'(f) + 32) % 32) + 1;
            aw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_dump(f, l, int'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1,
                     aw, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
